// File: rtl/cp0_ctrl.sv
// MIPS-style coprocessor 0 control block: Count/Compare timer, Status/Cause/EPC,
// exception entry and eret handling, and the combined interrupt request.
module cp0_ctrl #(
    parameter int          HW_IRQ_NUM   = 6,
    parameter int          COUNT_DIV    = 1,
    parameter logic [31:0] PRID_VALUE   = 32'h004C_0102,
    parameter logic [31:0] STATUS_WMASK = 32'h0000_FF03
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [4:0]            raddr_i,
    input  logic [31:0]           data_i,
    input  logic [HW_IRQ_NUM-1:0] hw_int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic [31:0]           exc_badvaddr_i,
    input  logic                  exc_bd_i,
    input  logic                  eret_i,
    output logic [31:0]           data_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  int_req_o,
    output logic                  timer_int_o
);

    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;
    localparam logic [4:0]  REG_PRID     = 5'd15;
    localparam logic [4:0]  REG_CONFIG   = 5'd16;
    localparam logic [31:0] CONFIG_VALUE = 32'h0000_8000;
    localparam logic [31:0] STATUS_RESET = 32'h1040_0000;

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        phase_q, phase_d;
    logic [31:0] status_q, status_d;
    logic        ti_q, ti_d;
    logic        bd_q, bd_d;
    logic [5:0]  hwIp_q, hwIp_d;
    logic [1:0]  swIp_q, swIp_d;
    logic [4:0]  excCode_q, excCode_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badVAddr_q, badVAddr_d;

    logic        wrCount, wrCompare, wrStatus, wrCause, wrEpc;
    logic [7:0]  ip;
    logic [31:0] causeVal;

    assign wrCount   = we_i && (waddr_i == REG_COUNT);
    assign wrCompare = we_i && (waddr_i == REG_COMPARE);
    assign wrStatus  = we_i && (waddr_i == REG_STATUS);
    assign wrCause   = we_i && (waddr_i == REG_CAUSE);
    assign wrEpc     = we_i && (waddr_i == REG_EPC);

    // The timer shares IP7 with the highest hardware line.
    assign ip       = {hwIp_q[5] | ti_q, hwIp_q[4:0], swIp_q};
    assign causeVal = {bd_q, ti_q, 14'd0, ip, 1'b0, excCode_q, 2'b00};

    always_comb begin
        count_d    = count_q;
        phase_d    = phase_q;
        compare_d  = compare_q;
        ti_d       = ti_q;
        hwIp_d     = 6'(hw_int_i);
        status_d   = status_q;
        swIp_d     = swIp_q;
        bd_d       = bd_q;
        excCode_d  = excCode_q;
        epc_d      = epc_q;
        badVAddr_d = badVAddr_q;

        if (wrCount) begin
            count_d = data_i;
            phase_d = 1'b0;
        end else begin
            if (COUNT_DIV == 1 || phase_q)
                count_d = count_q + 32'd1;
            phase_d = (COUNT_DIV == 2) ? ~phase_q : 1'b0;
        end

        if (wrCompare) begin
            compare_d = data_i;
            ti_d      = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end

        if (wrStatus)
            status_d = (status_q & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
        if (wrCause)
            swIp_d = data_i[9:8];
        if (wrEpc)
            epc_d = data_i;

        // Exception fields override any mtc0 to the same register; eret loses.
        if (exc_valid_i) begin
            status_d[1] = 1'b1;
            excCode_d   = exc_code_i;
            if (!status_q[1]) begin
                epc_d = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
                bd_d  = exc_bd_i;
            end
            if (exc_code_i == 5'd4 || exc_code_i == 5'd5)
                badVAddr_d = exc_badvaddr_i;
        end else if (eret_i) begin
            status_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= 32'd0;
            phase_q    <= 1'b0;
            compare_q  <= 32'd0;
            ti_q       <= 1'b0;
            hwIp_q     <= 6'd0;
            status_q   <= STATUS_RESET;
            swIp_q     <= 2'd0;
            bd_q       <= 1'b0;
            excCode_q  <= 5'd0;
            epc_q      <= 32'd0;
            badVAddr_q <= 32'd0;
        end else begin
            count_q    <= count_d;
            phase_q    <= phase_d;
            compare_q  <= compare_d;
            ti_q       <= ti_d;
            hwIp_q     <= hwIp_d;
            status_q   <= status_d;
            swIp_q     <= swIp_d;
            bd_q       <= bd_d;
            excCode_q  <= excCode_d;
            epc_q      <= epc_d;
            badVAddr_q <= badVAddr_d;
        end
    end

    always_comb begin
        data_o = 32'd0;
        case (raddr_i)
            REG_BADVADDR: data_o = badVAddr_q;
            REG_COUNT:    data_o = count_q;
            REG_COMPARE:  data_o = compare_q;
            REG_STATUS:   data_o = status_q;
            REG_CAUSE:    data_o = causeVal;
            REG_EPC:      data_o = epc_q;
            REG_PRID:     data_o = PRID_VALUE;
            REG_CONFIG:   data_o = CONFIG_VALUE;
            default:      data_o = 32'd0;
        endcase
    end

    assign status_o    = status_q;
    assign cause_o     = causeVal;
    assign epc_o       = epc_q;
    assign timer_int_o = ti_q;
    assign int_req_o   = status_q[0] & ~status_q[1] & |(ip & status_q[15:8]);

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an architectural model.
module tb_cp0_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, we, exc, bd, eret;
    logic [4:0]  waddr, raddr, code;
    logic [31:0] data, pc, badv;
    logic [5:0]  hw;
    logic [31:0] dataO, statusO, causeO, epcO;
    logic        intReq, timerInt;

    logic        bRst, bWe;
    logic [4:0]  bWaddr, bRaddr;
    logic [31:0] bData;
    logic [1:0]  bHw;
    logic [31:0] bDataO, bStatusO, bCauseO, bEpcO;
    logic        bIntReq, bTimerInt;

    int checks = 0;
    int errors = 0;

    cp0_ctrl dut (
        .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .raddr_i(raddr),
        .data_i(data), .hw_int_i(hw), .exc_valid_i(exc), .exc_code_i(code),
        .exc_pc_i(pc), .exc_badvaddr_i(badv), .exc_bd_i(bd), .eret_i(eret),
        .data_o(dataO), .status_o(statusO), .cause_o(causeO), .epc_o(epcO),
        .int_req_o(intReq), .timer_int_o(timerInt)
    );

    cp0_ctrl #(.HW_IRQ_NUM(2), .COUNT_DIV(2)) dutB (
        .clk(clk), .rst(bRst), .we_i(bWe), .waddr_i(bWaddr), .raddr_i(bRaddr),
        .data_i(bData), .hw_int_i(bHw), .exc_valid_i(1'b0), .exc_code_i(5'd0),
        .exc_pc_i(32'd0), .exc_badvaddr_i(32'd0), .exc_bd_i(1'b0), .eret_i(1'b0),
        .data_o(bDataO), .status_o(bStatusO), .cause_o(bCauseO), .epc_o(bEpcO),
        .int_req_o(bIntReq), .timer_int_o(bTimerInt)
    );

    // Architectural state of the default-parameter instance.
    logic [31:0] mCount, mCompare, mStatus, mEpc, mBadV;
    logic        mTi, mBd;
    logic [5:0]  mHw;
    logic [1:0]  mSw;
    logic [4:0]  mExc;
    bit          modelValid = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] causeModel();
        logic [31:0] ipBits;
        ipBits = 32'(mSw) + (32'(mHw) << 2);
        if (mTi) ipBits = ipBits | 32'h80;
        return (32'(mBd) << 31) + (32'(mTi) << 30) + (ipBits << 8) + (32'(mExc) << 2);
    endfunction

    function automatic logic [31:0] readModel(input logic [4:0] a);
        case (a)
            5'd8:    return mBadV;
            5'd9:    return mCount;
            5'd11:   return mCompare;
            5'd12:   return mStatus;
            5'd13:   return causeModel();
            5'd14:   return mEpc;
            5'd15:   return 32'h004C_0102;
            5'd16:   return 32'h0000_8000;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic intModel();
        logic [31:0] c;
        c = causeModel();
        return mStatus[0] && !mStatus[1] && ((c[15:8] & mStatus[15:8]) != 8'd0);
    endfunction

    always @(posedge clk) begin : model
        logic oldExl;
        logic match;
        if (rst) begin
            mCount = 0; mCompare = 0; mStatus = 32'h1040_0000; mEpc = 0; mBadV = 0;
            mTi = 0; mBd = 0; mHw = 0; mSw = 0; mExc = 0;
            modelValid = 1'b1;
        end else begin
            oldExl = mStatus[1];
            match  = (mCount == mCompare);
            if (we && waddr == 11) mTi = 1'b0;
            else if (match)        mTi = 1'b1;
            mCount = (we && waddr == 9) ? data : mCount + 1;
            if (we && waddr == 11) mCompare = data;
            mHw = hw;
            if (we && waddr == 12) mStatus = (mStatus & ~32'h0000_FF03) | (data & 32'h0000_FF03);
            if (we && waddr == 13) mSw = data[9:8];
            if (we && waddr == 14) mEpc = data;
            if (exc) begin
                mStatus[1] = 1'b1;
                mExc = code;
                if (!oldExl) begin
                    mEpc = bd ? pc - 32'd4 : pc;
                    mBd  = bd;
                end
                if (code == 4 || code == 5) mBadV = badv;
            end else if (eret) begin
                mStatus[1] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("data_o", dataO, readModel(raddr));
            checkOutput("status_o", statusO, mStatus);
            checkOutput("cause_o", causeO, causeModel());
            checkOutput("epc_o", epcO, mEpc);
            checkOutput("int_req_o", 32'(intReq), 32'(intModel()));
            checkOutput("timer_int_o", 32'(timerInt), 32'(mTi));
        end
    end

    task automatic stepIdle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] d,
                                 input logic e, input logic [4:0] c, input logic [31:0] p,
                                 input logic [31:0] bv, input logic b, input logic er);
        we = w; waddr = wa; data = d; exc = e; code = c; pc = p; badv = bv; bd = b; eret = er;
        stepIdle();
        we = 1'b0; exc = 1'b0; eret = 1'b0;
    endtask

    task automatic readReg(input logic [4:0] a, input string name, input logic [31:0] exp);
        raddr = a;
        #1;
        checkOutput(name, dataO, exp);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] codes [7];
        int n;
        codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12, 5'd13};
        rst = 1; we = 0; waddr = 0; raddr = 0; data = 0; hw = 0; exc = 0; code = 0;
        pc = 0; badv = 0; bd = 0; eret = 0;
        bRst = 1; bWe = 0; bWaddr = 0; bRaddr = 0; bData = 0; bHw = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;

        readReg(12, "reset status", 32'h1040_0000);
        readReg(15, "prid", 32'h004C_0102);
        readReg(16, "config", 32'h0000_8000);
        checkOutput("reset int_req", 32'(intReq), 32'd0);
        stepIdle();
        readReg(10, "unmapped", 32'd0);

        applyStimulus(1, 11, 32'd20, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 9, 32'd10, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 12, 32'h0000_8001, 0, 0, 0, 0, 0, 0);
        checkOutput("ti before match", 32'(timerInt), 32'd0);
        n = 0;
        while (!timerInt && n < 40) begin
            stepIdle();
            n++;
        end
        checkOutput("ti latency", 32'(n), 32'd10);
        checkOutput("ip7", 32'(causeO[15]), 32'd1);
        checkOutput("timer int_req", 32'(intReq), 32'd1);
        applyStimulus(1, 11, 32'h0000_1000, 0, 0, 0, 0, 0, 0);
        checkOutput("ti cleared", 32'(timerInt), 32'd0);

        applyStimulus(1, 9, 32'd200, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 11, 32'd201, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 11, 32'd500, 0, 0, 0, 0, 0, 0);
        checkOutput("match vs compare write", 32'(timerInt), 32'd0);

        applyStimulus(0, 0, 0, 1, 5'd12, 32'h100, 0, 1, 0);
        checkOutput("epc bd", epcO, 32'hFC);
        checkOutput("cause bd", 32'(causeO[31]), 32'd1);
        checkOutput("exccode 12", 32'(causeO[6:2]), 32'd12);
        checkOutput("exl set", 32'(statusO[1]), 32'd1);
        applyStimulus(0, 0, 0, 1, 5'd8, 32'h200, 0, 0, 0);
        checkOutput("nested epc", epcO, 32'hFC);
        checkOutput("nested exccode", 32'(causeO[6:2]), 32'd8);
        checkOutput("nested bd", 32'(causeO[31]), 32'd1);

        applyStimulus(0, 0, 0, 1, 5'd4, 32'h300, 32'hDEAD_BEE1, 0, 0);
        readReg(8, "badvaddr adel", 32'hDEAD_BEE1);
        applyStimulus(0, 0, 0, 1, 5'd10, 32'h304, 32'h1234_5678, 0, 0);
        readReg(8, "badvaddr ri", 32'hDEAD_BEE1);

        applyStimulus(1, 12, 32'd0, 1, 5'd13, 32'h400, 0, 0, 1);
        checkOutput("collision exl", 32'(statusO[1]), 32'd1);
        checkOutput("collision ie", 32'(statusO[0]), 32'd0);
        checkOutput("collision im", 32'(statusO[15:8]), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("eret clears exl", 32'(statusO[1]), 32'd0);

        for (int i = 0; i < 2000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            we    = ($urandom_range(0, 3) == 0);
            data  = $urandom;
            case ($urandom_range(0, 9))
                0: waddr = 5'd8;
                1: waddr = 5'd9;
                2: waddr = 5'd11;
                3: waddr = 5'd12;
                4: waddr = 5'd13;
                5: waddr = 5'd14;
                6: waddr = 5'd15;
                7: waddr = 5'd16;
                8: waddr = 5'($urandom);
                default: begin
                    waddr = 5'd11;
                    data  = mCount + 32'($urandom_range(2, 6));
                end
            endcase
            exc   = ($urandom_range(0, 9) == 0);
            code  = codes[$urandom_range(0, 6)];
            pc    = $urandom;
            badv  = $urandom;
            bd    = 1'($urandom);
            eret  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) hw = 6'($urandom);
            raddr = 5'($urandom_range(0, 31));
            stepIdle();
        end
        rst = 0; we = 0; exc = 0; eret = 0;

        bRst = 0;
        bWe = 1; bWaddr = 11; bData = 32'hFFFF_0000;
        stepIdle();
        bWaddr = 9; bData = 32'd0;
        stepIdle();
        bWe = 0; bRaddr = 9;
        #1;
        checkOutput("div2 load", bDataO, 32'd0);
        stepIdle();
        checkOutput("div2 hold", bDataO, 32'd0);
        stepIdle();
        checkOutput("div2 first inc", bDataO, 32'd1);
        stepIdle();
        stepIdle();
        checkOutput("div2 second inc", bDataO, 32'd2);
        bWe = 1; bWaddr = 12; bData = 32'h0000_0801;
        stepIdle();
        bWe = 0; bHw = 2'b10;
        #1;
        checkOutput("b ie", 32'(bStatusO[0]), 32'd1);
        checkOutput("ip3 not yet", 32'(bCauseO[11]), 32'd0);
        stepIdle();
        checkOutput("ip3 set", 32'(bCauseO[11]), 32'd1);
        checkOutput("ip7..4 zero", 32'(bCauseO[15:12]), 32'd0);
        checkOutput("b int_req", 32'(bIntReq), 32'd1);
        checkOutput("b timer", 32'(bTimerInt), 32'd0);
        checkOutput("b epc", bEpcO, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
